// File: rtl/devil_pkg.sv
// Shared definitions for the devil controller: FSM state encodings, command codes,
// ACE snoop opcodes used by the active devil, and the cache-line width helper.
package devil_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_CHOOSE     = 4'd1,
        ST_REROUTE    = 4'd2,
        ST_LEAK_WAIT  = 4'd3,
        ST_LEAK_CMP   = 4'd4,
        ST_LEAK_ACT   = 4'd5,
        ST_LEAK_REPLY = 4'd6,
        ST_POISON     = 4'd7,
        ST_END_OP     = 4'd8
    } devil_state_t;

    localparam logic [3:0] CMD_REROUTING = 4'd0;
    localparam logic [3:0] CMD_LEAK      = 4'd1;
    localparam logic [3:0] CMD_POISON    = 4'd2;

    // ACE snoop opcodes: ADL reads a line without changing ownership (ReadOnce),
    // ADT takes the line unique (ReadUnique) so it can be tainted.
    localparam logic [3:0] SNOOP_ADL = 4'b0000;
    localparam logic [3:0] SNOOP_ADT = 4'b0111;

    localparam int WORD_W = 32;

    function automatic int cl_w(input int data_w);
        return 4 * data_w;
    endfunction

endpackage

// File: rtl/devil_pattern_matcher.sv
// Combinational word-masked compare of one cache line against every pattern slot,
// followed by a priority encoder where the lowest-numbered hitting slot wins.
module devil_pattern_matcher
    import devil_pkg::*;
#(
    parameter int CL_W         = 512,
    parameter int NUM_PATTERNS = 4,
    parameter int IDX_W        = 2
) (
    input  logic [CL_W-1:0]                         line,
    input  logic [NUM_PATTERNS*CL_W-1:0]            patterns,
    input  logic [NUM_PATTERNS*(CL_W/WORD_W)-1:0]   masks,
    output logic                                    hit,
    output logic [IDX_W-1:0]                        idx
);

    localparam int WORDS = CL_W / WORD_W;

    logic [NUM_PATTERNS-1:0] slot_hit;

    // A slot with no enabled words must never hit, hence the OR-reduce seed.
    always_comb begin
        slot_hit = '0;
        for (int k = 0; k < NUM_PATTERNS; k++) begin
            slot_hit[k] = |masks[k*WORDS +: WORDS];
            for (int w = 0; w < WORDS; w++) begin
                if (masks[k*WORDS + w] &&
                    (line[w*WORD_W +: WORD_W] != patterns[k*CL_W + w*WORD_W +: WORD_W])) begin
                    slot_hit[k] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int k = NUM_PATTERNS - 1; k >= 0; k--) begin
            if (slot_hit[k]) begin
                hit = 1'b1;
                idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/devil_controller_mp.sv
// Devil controller: sequences reroute/leak/poison replies and matches captured lines
// against programmable masked patterns. Optional macro DEVIL_HIT_COUNTERS_EN adds per-slot hit counters.
module devil_controller_mp
    import devil_pkg::*;
#(
    parameter int          C_ACE_DATA_WIDTH = 128,
    parameter int          C_ACE_ADDR_WIDTH = 44,
    parameter int          NUM_PATTERNS     = 4,
    parameter int          DEVIL_STATE_SIZE = 4,
    parameter int          TIMEOUT_CYCLES   = 1024,
    parameter logic [31:0] POISON_WORD      = 32'hDEADDEAD,
    localparam int         CL_W             = cl_w(C_ACE_DATA_WIDTH),
    localparam int         WORDS            = CL_W / WORD_W,
    localparam int         IDX_W            = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1
) (
    input  logic                          ace_aclk,
    input  logic                          ace_areset,
    input  logic                          i_trigger,
    input  logic [3:0]                    i_cmd,
    input  logic [C_ACE_ADDR_WIDTH-1:0]   i_act_addr,
    input  logic [3:0]                    i_act_snoop,
    input  logic                          i_pat_wr_en,
    input  logic [IDX_W-1:0]              i_pat_wr_idx,
    input  logic [CL_W-1:0]               i_pat_wr_data,
    input  logic [WORDS-1:0]              i_pat_wr_mask,
    input  logic                          i_end_active_devil,
    input  logic [CL_W-1:0]               i_cache_line_active_devil,
    input  logic                          i_end_reply,
    input  logic                          i_act_ack,
    output logic [DEVIL_STATE_SIZE-1:0]   o_fsm,
    output logic                          o_busy,
    output logic                          o_reply,
    output logic [CL_W-1:0]               o_reply_line,
    output logic                          o_act_req,
    output logic [C_ACE_ADDR_WIDTH-1:0]   o_act_addr,
    output logic [3:0]                    o_act_snoop,
    output logic                          o_match_valid,
    output logic [IDX_W-1:0]              o_match_idx,
    output logic                          o_timeout
`ifdef DEVIL_HIT_COUNTERS_EN
    ,
    output logic [NUM_PATTERNS*16-1:0]    o_hit_count
`endif
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    devil_state_t state, next_state;

    logic [NUM_PATTERNS*CL_W-1:0]  pat_data;
    logic [NUM_PATTERNS*WORDS-1:0] pat_mask;
    logic [CL_W-1:0]               r_save;
    logic [3:0]                    r_cmd;
    logic                          r_reroute;
    logic [TO_W-1:0]               to_cnt;
    logic                          m_hit;
    logic [IDX_W-1:0]              m_idx;
    logic                          pat_wr_ok;

    assign pat_wr_ok = i_pat_wr_en && (state == ST_IDLE);

    devil_pattern_matcher #(
        .CL_W         (CL_W),
        .NUM_PATTERNS (NUM_PATTERNS),
        .IDX_W        (IDX_W)
    ) u_matcher (
        .line     (r_save),
        .patterns (pat_data),
        .masks    (pat_mask),
        .hit      (m_hit),
        .idx      (m_idx)
    );

    always_ff @(posedge ace_aclk or posedge ace_areset) begin
        if (ace_areset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:      if (i_trigger) next_state = ST_CHOOSE;
            ST_CHOOSE: begin
                case (r_cmd)
                    CMD_REROUTING, CMD_LEAK: next_state = ST_LEAK_WAIT;
                    CMD_POISON:              next_state = ST_POISON;
                    default:                 next_state = ST_END_OP;
                endcase
            end
            ST_LEAK_WAIT: if (i_end_active_devil) next_state = r_reroute ? ST_REROUTE : ST_LEAK_CMP;
            ST_LEAK_CMP:  next_state = m_hit ? ST_LEAK_ACT : ST_REROUTE;
            ST_LEAK_ACT:  if (i_act_ack || (to_cnt == TO_LAST)) next_state = ST_LEAK_REPLY;
            ST_REROUTE, ST_LEAK_REPLY, ST_POISON:
                          if (i_end_reply) next_state = ST_END_OP;
            ST_END_OP:    next_state = ST_IDLE;
            default:      next_state = ST_IDLE;
        endcase
    end

    // Pattern slots are only writable while idle so a compare never sees a half-updated slot.
    always_ff @(posedge ace_aclk or posedge ace_areset) begin
        if (ace_areset) begin
            pat_data <= '0;
            pat_mask <= '0;
        end else begin
            for (int k = 0; k < NUM_PATTERNS; k++) begin
                if (pat_wr_ok && (i_pat_wr_idx == IDX_W'(k))) begin
                    pat_data[k*CL_W +: CL_W]   <= i_pat_wr_data;
                    pat_mask[k*WORDS +: WORDS] <= i_pat_wr_mask;
                end
            end
        end
    end

    always_ff @(posedge ace_aclk or posedge ace_areset) begin
        if (ace_areset) begin
            r_cmd         <= '0;
            r_reroute     <= 1'b0;
            r_save        <= '0;
            to_cnt        <= '0;
            o_act_addr    <= '0;
            o_act_snoop   <= '0;
            o_match_valid <= 1'b0;
            o_match_idx   <= '0;
            o_timeout     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_trigger) begin
                        r_cmd       <= i_cmd;
                        o_act_addr  <= i_act_addr;
                        o_act_snoop <= i_act_snoop;
                        o_timeout   <= 1'b0;
                    end
                end
                ST_CHOOSE: begin
                    r_reroute <= (r_cmd == CMD_REROUTING);
                    if (r_cmd == CMD_LEAK) o_match_valid <= 1'b0;
                end
                ST_LEAK_WAIT: begin
                    if (i_end_active_devil) r_save <= i_cache_line_active_devil;
                end
                ST_LEAK_CMP: begin
                    to_cnt <= '0;
                    if (m_hit) begin
                        o_match_valid <= 1'b1;
                        o_match_idx   <= m_idx;
                    end
                end
                ST_LEAK_ACT: begin
                    if (!i_act_ack) begin
                        if (to_cnt == TO_LAST) o_timeout <= 1'b1;
                        else                   to_cnt    <= to_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_reply      = 1'b0;
        o_reply_line = '0;
        case (state)
            ST_REROUTE, ST_LEAK_REPLY: begin
                o_reply      = 1'b1;
                o_reply_line = r_save;
            end
            ST_POISON: begin
                o_reply      = 1'b1;
                o_reply_line = {WORDS{POISON_WORD}};
            end
            default: ;
        endcase
    end

    assign o_act_req = (state == ST_LEAK_ACT);
    assign o_busy    = (state != ST_IDLE);
    assign o_fsm     = DEVIL_STATE_SIZE'(state);

`ifdef DEVIL_HIT_COUNTERS_EN
    logic [NUM_PATTERNS*16-1:0] hit_cnt;

    // Counters saturate at all-ones; rewriting a slot restarts its count.
    always_ff @(posedge ace_aclk or posedge ace_areset) begin
        if (ace_areset) begin
            hit_cnt <= '0;
        end else begin
            for (int k = 0; k < NUM_PATTERNS; k++) begin
                if (pat_wr_ok && (i_pat_wr_idx == IDX_W'(k))) begin
                    hit_cnt[k*16 +: 16] <= 16'd0;
                end else if ((state == ST_LEAK_CMP) && m_hit && (m_idx == IDX_W'(k)) &&
                             (hit_cnt[k*16 +: 16] != 16'hFFFF)) begin
                    hit_cnt[k*16 +: 16] <= hit_cnt[k*16 +: 16] + 16'd1;
                end
            end
        end
    end

    assign o_hit_count = hit_cnt;
`endif

endmodule

// File: tb/tb_devil_controller_mp.sv
// Self-checking bench for devil_controller_mp: directed steps with a reply-line scoreboard.
module tb_devil_controller_mp;

    localparam int CL = 512;
    localparam int NW = 16;
    localparam int AW = 44;
    localparam int NP = 4;
    localparam int IW = 2;
    localparam int TO = 8;

    localparam logic [3:0] S_IDLE = 4'd0, S_CHOOSE = 4'd1, S_REROUTE = 4'd2, S_WAIT = 4'd3,
                           S_CMP = 4'd4, S_ACT = 4'd5, S_LREPLY = 4'd6, S_POISON = 4'd7,
                           S_END = 4'd8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          trigger = 1'b0;
    logic [3:0]    cmd = '0;
    logic [AW-1:0] act_addr = '0;
    logic [3:0]    act_snoop = '0;
    logic          pat_wr_en = 1'b0;
    logic [IW-1:0] pat_wr_idx = '0;
    logic [CL-1:0] pat_wr_data = '0;
    logic [NW-1:0] pat_wr_mask = '0;
    logic          end_active = 1'b0;
    logic [CL-1:0] cap_line = '0;
    logic          end_reply = 1'b0;
    logic          act_ack = 1'b0;

    logic [3:0]    fsm;
    logic          busy, reply, act_req, match_valid, timeout;
    logic [CL-1:0] reply_line;
    logic [AW-1:0] act_addr_q;
    logic [3:0]    act_snoop_q;
    logic [IW-1:0] match_idx;
`ifdef DEVIL_HIT_COUNTERS_EN
    logic [NP*16-1:0] hit_count;
`endif

    int total = 0;
    int bad   = 0;
    logic [CL-1:0] exp_q[$];

    logic [CL-1:0] l2, l3, l4, l5, p1, poison_line;

    devil_controller_mp #(
        .C_ACE_DATA_WIDTH (128),
        .C_ACE_ADDR_WIDTH (AW),
        .NUM_PATTERNS     (NP),
        .DEVIL_STATE_SIZE (4),
        .TIMEOUT_CYCLES   (TO),
        .POISON_WORD      (32'hDEADDEAD)
    ) dut (
        .ace_aclk                  (clk),
        .ace_areset                (rst),
        .i_trigger                 (trigger),
        .i_cmd                     (cmd),
        .i_act_addr                (act_addr),
        .i_act_snoop               (act_snoop),
        .i_pat_wr_en               (pat_wr_en),
        .i_pat_wr_idx              (pat_wr_idx),
        .i_pat_wr_data             (pat_wr_data),
        .i_pat_wr_mask             (pat_wr_mask),
        .i_end_active_devil        (end_active),
        .i_cache_line_active_devil (cap_line),
        .i_end_reply               (end_reply),
        .i_act_ack                 (act_ack),
        .o_fsm                     (fsm),
        .o_busy                    (busy),
        .o_reply                   (reply),
        .o_reply_line              (reply_line),
        .o_act_req                 (act_req),
        .o_act_addr                (act_addr_q),
        .o_act_snoop               (act_snoop_q),
        .o_match_valid             (match_valid),
        .o_match_idx               (match_idx),
        .o_timeout                 (timeout)
`ifdef DEVIL_HIT_COUNTERS_EN
        ,
        .o_hit_count               (hit_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the directed sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [CL-1:0] obs, input logic [CL-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CL-1:0] rand_line();
        logic [CL-1:0] l;
        for (int i = 0; i < NW; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic write_pat(input logic [IW-1:0] idx, input logic [CL-1:0] data, input logic [NW-1:0] mask);
        pat_wr_en = 1'b1; pat_wr_idx = idx; pat_wr_data = data; pat_wr_mask = mask;
        tick();
        pat_wr_en = 1'b0;
    endtask

    // Trigger a reroute/leak and deliver the captured line; returns one edge after capture.
    task automatic apply_stimulus(input logic [3:0] c, input logic [AW-1:0] addr,
                                  input logic [3:0] snp, input logic [CL-1:0] line);
        trigger = 1'b1; cmd = c; act_addr = addr; act_snoop = snp;
        tick();
        trigger = 1'b0; act_addr = ~addr; act_snoop = ~snp;
        check_output("choose_state", fsm, S_CHOOSE);
        check_output("timeout_cleared", timeout, 1'b0);
        tick();
        check_output("leak_wait_state", fsm, S_WAIT);
        end_active = 1'b1; cap_line = line;
        tick();
        end_active = 1'b0; cap_line = rand_line();
    endtask

    task automatic finish_reply(input string tag);
        logic [CL-1:0] exp;
        check_output({tag, "_reply_hi"}, reply, 1'b1);
        check_output({tag, "_sb_nonempty"}, exp_q.size() > 0, 1'b1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check_output({tag, "_line"}, reply_line, exp);
        tick();
        check_output({tag, "_line_held"}, reply_line, exp);
        end_reply = 1'b1;
        tick();
        end_reply = 1'b0;
        check_output({tag, "_end_op"}, fsm, S_END);
        check_output({tag, "_reply_lo"}, reply, 1'b0);
        tick();
        check_output({tag, "_idle"}, fsm, S_IDLE);
    endtask

    initial begin
        poison_line = {NW{32'hDEADDEAD}};
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_fsm", fsm, S_IDLE);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_reply", reply, 1'b0);
        check_output("rst_act_req", act_req, 1'b0);
        check_output("rst_match_valid", match_valid, 1'b0);
        check_output("rst_timeout", timeout, 1'b0);
        rst = 1'b0;
        tick();

        $display("[TB] single-slot hit on slot 2");
        l2 = rand_line();
        write_pat(2'd2, l2, 16'hFFFF);
        exp_q.push_back(l2);
        apply_stimulus(4'd1, 44'h0AB_CDEF_1234, 4'h3, l2);
        check_output("hit_cmp_state", fsm, S_CMP);
        tick();
        check_output("hit_act_state", fsm, S_ACT);
        check_output("hit_match_valid", match_valid, 1'b1);
        check_output("hit_match_idx", match_idx, 2'd2);
        check_output("hit_act_req", act_req, 1'b1);
        tick();
        check_output("hit_act_req_held", act_req, 1'b1);
        check_output("hit_act_addr", act_addr_q, 44'h0AB_CDEF_1234);
        check_output("hit_act_snoop", act_snoop_q, 4'h3);
        act_ack = 1'b1;
        tick();
        act_ack = 1'b0;
        check_output("hit_reply_state", fsm, S_LREPLY);
        check_output("hit_req_dropped", act_req, 1'b0);
        finish_reply("hit");

        $display("[TB] two matching slots, lowest wins");
        l3 = rand_line();
        p1 = rand_line();
        p1[127:0] = l3[127:0];
        write_pat(2'd1, p1, 16'h000F);
        write_pat(2'd3, l3, 16'hFFFF);
        exp_q.push_back(l3);
        apply_stimulus(4'd1, 44'h123, 4'h1, l3);
        tick();
        check_output("prio_act_state", fsm, S_ACT);
        check_output("prio_match_idx", match_idx, 2'd1);
        act_ack = 1'b1;
        tick();
        act_ack = 1'b0;
        finish_reply("prio");

        $display("[TB] miss falls back to reroute");
        l4 = rand_line();
        exp_q.push_back(l4);
        apply_stimulus(4'd1, 44'h456, 4'h2, l4);
        tick();
        check_output("miss_state", fsm, S_REROUTE);
        check_output("miss_match_valid", match_valid, 1'b0);
        check_output("miss_act_req", act_req, 1'b0);
        finish_reply("miss");

        $display("[TB] reroute command skips compare");
        exp_q.push_back(l2);
        apply_stimulus(4'd0, 44'h789, 4'h0, l2);
        check_output("reroute_state", fsm, S_REROUTE);
        finish_reply("reroute");

        $display("[TB] ack timeout");
        exp_q.push_back(l2);
        apply_stimulus(4'd1, 44'h111, 4'h4, l2);
        tick();
        check_output("to_act_entry", fsm, S_ACT);
        repeat (TO - 1) tick();
        check_output("to_act_cycle8", fsm, S_ACT);
        check_output("to_req_cycle8", act_req, 1'b1);
        tick();
        check_output("to_reply_state", fsm, S_LREPLY);
        check_output("to_req_dropped", act_req, 1'b0);
        check_output("to_flag", timeout, 1'b1);
        finish_reply("timeout");

        $display("[TB] ack on final cycle beats timeout");
        exp_q.push_back(l2);
        apply_stimulus(4'd1, 44'h222, 4'h5, l2);
        tick();
        repeat (TO - 1) tick();
        check_output("lastack_act_state", fsm, S_ACT);
        act_ack = 1'b1;
        tick();
        act_ack = 1'b0;
        check_output("lastack_reply_state", fsm, S_LREPLY);
        check_output("lastack_timeout", timeout, 1'b0);
        finish_reply("lastack");

        $display("[TB] poison");
        exp_q.push_back(poison_line);
        trigger = 1'b1; cmd = 4'd2;
        tick();
        trigger = 1'b0;
        check_output("poison_choose", fsm, S_CHOOSE);
        tick();
        check_output("poison_state", fsm, S_POISON);
        finish_reply("poison");

        $display("[TB] unknown command");
        trigger = 1'b1; cmd = 4'hF;
        tick();
        trigger = 1'b0;
        tick();
        check_output("noop_end_op", fsm, S_END);
        check_output("noop_no_reply", reply, 1'b0);
        tick();
        check_output("noop_idle", fsm, S_IDLE);

        $display("[TB] pattern write while busy is dropped");
        l5 = rand_line();
        trigger = 1'b1; cmd = 4'd1;
        tick();
        trigger = 1'b0;
        tick();
        end_reply = 1'b1;
        write_pat(2'd0, l5, 16'hFFFF);
        end_reply = 1'b0;
        check_output("busy_wr_still_wait", fsm, S_WAIT);
        exp_q.push_back(l5);
        end_active = 1'b1; cap_line = l5;
        tick();
        end_active = 1'b0;
        tick();
        check_output("busy_wr_miss", fsm, S_REROUTE);
        finish_reply("busy_wr");

        $display("[TB] async reset during active request");
        apply_stimulus(4'd1, 44'h333, 4'h6, l2);
        tick();
        check_output("rstact_req_before", act_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_output("rstact_req_dropped", act_req, 1'b0);
        check_output("rstact_fsm", fsm, S_IDLE);
        check_output("rstact_match_valid", match_valid, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        exp_q.push_back('0);
        apply_stimulus(4'd1, 44'h444, 4'h7, '0);
        tick();
        check_output("rstact_zero_mask_miss", fsm, S_REROUTE);
        finish_reply("rst_zero");
        exp_q.push_back(l2);
        apply_stimulus(4'd1, 44'h555, 4'h8, l2);
        tick();
        check_output("rstact_slots_cleared", fsm, S_REROUTE);
        finish_reply("rst_l2");

`ifdef DEVIL_HIT_COUNTERS_EN
        $display("[TB] hit counters");
        write_pat(2'd0, l2, 16'hFFFF);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(l2);
            apply_stimulus(4'd1, 44'h666, 4'h9, l2);
            tick();
            act_ack = 1'b1;
            tick();
            act_ack = 1'b0;
            finish_reply("cnt");
        end
        check_output("hit_count_slot0", hit_count[15:0], 16'd3);
`endif

        check_output("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
